uart_rx_fifo_less: RTL
======================

// Module: uart_rx_fifo_less
// PURPOSE
//  8N1 UART receiver with 16x oversampling. Sits between pin uart_txd_in and
//  the I2C command decoder. Produces one byte at a time on a valid/ready
//  handshake and holds it in a single buffer. Drives uart_cts to throttle the host.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  input clock frequency
//  BAUD         115200       serial bit rate
//  OVERSAMPLE   16           ticks per bit; DIV = round(CLK_FREQ_HZ/(BAUD*OVERSAMPLE)) = 54
// PORTS
//  clk_100M   in   1  system clock; single clock domain
//  rst        in   1  synchronous, active-high reset
//  rxd        in   1  asynchronous serial input (uart_txd_in); idles high
//  rx_data    out  8  received byte; stable while rx_valid=1
//  rx_valid   out  1  byte available in the holding register
//  rx_ready   in   1  consumer accepts; transfer = rx_valid & rx_ready
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  overrun    out  1  1-cycle pulse: byte completed while the buffer was full; new byte dropped
//  cts        out  1  registered; 1 = host may send (= ~rx_valid, delayed one cycle)
// BEHAVIOUR
//  - Reset: sync FFs=1, state=IDLE, tick/bit counters=0, rx_data=0, rx_valid=0,
//    frame_err=0, overrun=0, cts=0. cts rises on the first cycle after rst deasserts.
//  - rxd passes through a 2-FF synchronizer; all decisions use the synced value (rxs).
//  - Tick generator: a counter 0..DIV-1 emits a 1-cycle tick at DIV-1. It is cleared
//    in IDLE, so bit timing aligns to the detected start edge.
//  - FSM:
//    IDLE: when rxs=0, go to START and clear tick_cnt.
//    START: at tick 7 (mid-bit), if rxs=1 treat as a glitch and return to IDLE.
//      Otherwise go to DATA with bit_cnt=0 and tick_cnt=0.
//    DATA: at tick 15 of each bit, shift rxs into shreg LSB-first and increment bit_cnt.
//      After bit 7, go to STOP.
//    STOP: at tick 15 (mid stop bit):
//      - rxs=1: commit the byte and go to IDLE.
//      - rxs=0: pulse frame_err, discard the byte, go to BREAK.
//    BREAK: wait for rxs=1, then go to IDLE. A held-low line (break) yields exactly one frame_err.
//  - Commit: rx_data <= shreg and rx_valid <= 1 on the cycle after the stop sample.
//    Latency from stop-bit mid to rx_valid is 1 clk.
//  - Handshake: rx_valid clears on the cycle after a transfer. rx_data must not change
//    while rx_valid=1 and rx_ready=0.
//  - Commit while rx_valid=1 and rx_ready=0: pulse overrun, drop the new byte, keep the old one.
//  - Commit in the same cycle as a transfer: load the new byte, rx_valid stays 1, no overrun.
//  - frame_err and overrun are never asserted for more than one cycle per frame.
//  - rst mid-frame: abort immediately to reset values. A partial byte is never committed.
// STRUCTURE
//  - uart_defs.vh (shared with the future uart_tx):
//    - state encodings: IDLE/START/DATA/STOP/BREAK
//    - OVERSAMPLE, MID_TICK=7, LAST_TICK=15
//    - divisor macro
//  - Sub-module uart_baud_tick (DIV param, clear input, tick output), reused by uart_tx.
//    Everything else stays inline.
// TESTING (BAUD=115200, DIV=54, bit=864 clk)
//  1. rst 4 clk, then send 0xA5 with rx_ready=1.
//     -> rx_data=0xA5 with one rx_valid pulse; no frame_err or overrun.
//  2. rx_ready=0, send 0x3C then 0x7E.
//     -> rx_data stays 0x3C, rx_valid held high, one overrun pulse, cts=0 after the first byte.
//  3. Send 0x55 with the stop bit driven low, then hold rxd low for 20 bit times.
//     -> exactly one frame_err, no rx_valid; a following 0x81 is received correctly.
//  4. Drive a 200-clk low glitch on an idle line.
//     -> FSM returns to IDLE; no rx_valid, no frame_err.
//  5. Assert rx_ready on the exact commit cycle of the second of two back-to-back bytes
//     (0x01, 0x02). -> 0x01 then 0x02 delivered, no overrun.
//  6. Assert rst at bit 4 of 0xFF, release, then send 0x12.
//     -> only 0x12 is delivered; outputs are at reset values while rst is high.
//  Also run with baud offset by +/-2% and 9600 baud (DIV=651); all bytes must be received intact.

Source files
------------

// File: rtl/uart_rx_fifo_less_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_less_pkg
//  Brief    : Shared UART state encoding, oversampling constants, divisor calc
//  Revision : 1.0
// ============================================================================
package uart_rx_fifo_less_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

    localparam int c_OVERSAMPLE = 16;
    localparam int c_MID_TICK   = c_OVERSAMPLE / 2 - 1;
    localparam int c_LAST_TICK  = c_OVERSAMPLE - 1;

    // Rounded clk / (baud * oversample).
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_less_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_less_baud_tick
//  Brief    : Free-running 0..DIV-1 divider with 1-cycle tick and sync clear
//  Revision : 1.0
// ============================================================================
module uart_rx_fifo_less_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST) && !clear;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo_less.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_less
//  Brief    : 8N1 UART receiver, 16x oversampled, single-byte valid/ready buffer
//  Revision : 1.0
// ============================================================================
module uart_rx_fifo_less
    import uart_rx_fifo_less_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = c_OVERSAMPLE
) (
    input  logic       clk_100M,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       cts
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] c_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_LAST = TW'(OVERSAMPLE - 1);

    logic [1:0]    r_sync;
    rx_state_t     r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;
    logic          r_cts;
    logic          w_rxs;
    logic          w_tick;
    logic          w_tick_clear;

    assign w_rxs        = r_sync[1];
    assign w_tick_clear = (r_state == S_IDLE);

    uart_rx_fifo_less_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk_100M),
        .rst   (rst),
        .clear (w_tick_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_cts       <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rxd};
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_cts       <= ~r_valid;

            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_MID) begin
                            // High at mid start bit: noise, not a frame.
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state    <= S_DATA;
                                r_bit_cnt  <= '0;
                                r_tick_cnt <= '0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_LAST) begin
                            r_shreg    <= {w_rxs, r_shreg[7:1]};
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_LAST) begin
                            r_tick_cnt <= '0;
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                                // A same-cycle transfer frees the buffer for the new byte.
                                if (r_valid && !rx_ready) begin
                                    r_overrun <= 1'b1;
                                end else begin
                                    r_data  <= r_shreg;
                                    r_valid <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign cts       = r_cts;

endmodule
`default_nettype wire
